// File: rtl/sa_input_skewer.sv
// sa_input_skewer: ping-pong row buffer that replays each buffered NxN
// activation matrix as a diagonally skewed stream (lane k delayed k beats).
module sa_input_skewer #(
  parameter int N  = 3,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [N*DW-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_first,
  output logic            out_last,
  output logic            frame_done,
  output logic [1:0]      bank_full
);
  localparam int STEPS = 2*N - 1;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int RW    = (N > 1) ? $clog2(N) : 1;
  localparam int LW    = N*DW;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t        r_state;
  logic [LW-1:0] r_mem [2][N];
  logic [1:0]    r_full;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [RW-1:0] r_row;
  logic [SW-1:0] r_step;
  logic [LW-1:0] r_out_data;
  logic          r_out_valid;
  logic          r_out_first;
  logic          r_out_last;
  logic          r_frame_done;

  logic          w_wr;
  logic          w_wr_last;
  logic          w_acc;
  logic          w_acc_last;
  logic          w_sel_bank;
  logic [SW-1:0] w_sel_step;
  logic [LW-1:0] w_beat;
  logic [1:0]    w_full_nxt;
  logic          w_unused_hi;

  assign in_ready    = !r_full[r_wr_bank];
  assign w_wr        = in_valid && in_ready;
  assign w_wr_last   = w_wr && (r_row == RW'(N-1));
  assign w_acc       = (r_state == S_STREAM) && r_out_valid && out_ready;
  assign w_acc_last  = w_acc && (r_step == SW'(STEPS-1));
  assign w_unused_hi = ^in_data[31:LW];

  // Beat to register next: the first load uses the current step, an accepted
  // last beat rolls over to step 0 of the other bank, otherwise advance.
  always_comb begin
    w_sel_bank = r_rd_bank;
    w_sel_step = r_step;
    if (r_out_valid) begin
      if (r_step == SW'(STEPS-1)) begin
        w_sel_bank = ~r_rd_bank;
        w_sel_step = '0;
      end else begin
        w_sel_step = r_step + SW'(1);
      end
    end
  end

  // Anti-diagonal select: element (r,k) appears on lane k at step r+k.
  always_comb begin
    w_beat = '0;
    for (int unsigned r = 0; r < N; r++)
      for (int unsigned k = 0; k < N; k++)
        if (r + k == 32'(w_sel_step))
          w_beat[k*DW +: DW] = r_mem[w_sel_bank][r][k*DW +: DW];
  end

  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_last)  w_full_nxt[r_wr_bank] = 1'b1;
    if (w_acc_last) w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_bank][r_row] <= in_data[LW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_full       <= '0;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_row        <= '0;
      r_step       <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_first  <= 1'b0;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_full       <= w_full_nxt;
      if (w_wr) begin
        if (w_wr_last) begin
          r_row     <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_row <= r_row + RW'(1);
        end
      end
      if (w_acc_last) begin
        r_rd_bank    <= ~r_rd_bank;
        r_frame_done <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (r_full[r_rd_bank]) begin
            r_state <= S_STREAM;
            r_step  <= '0;
          end
        end
        S_STREAM: begin
          if (w_acc_last && !r_full[~r_rd_bank]) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
          end else if (!r_out_valid || out_ready) begin
            r_out_valid <= 1'b1;
            r_step      <= w_sel_step;
            r_out_data  <= w_beat;
            r_out_first <= (w_sel_step == '0);
            r_out_last  <= (w_sel_step == SW'(STEPS-1));
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign out_first  = r_out_first;
  assign out_last   = r_out_last;
  assign frame_done = r_frame_done;
  assign bank_full  = r_full;

endmodule

// File: tb/tb_sa_input_skewer.sv
// Bench for sa_input_skewer: matrix-level skew model checked every cycle,
// plus directed scenarios pinned with hand-computed beats.
module tb_sa_input_skewer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_first;
  logic        out_last;
  logic        frame_done;
  logic [1:0]  bank_full;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sa_input_skewer #(.N(3), .DW(8)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_last(out_last),
    .frame_done(frame_done), .bank_full(bank_full)
  );

  typedef struct {
    logic [23:0] d;
    logic        f;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  logic [23:0] rows[$];
  logic [23:0] got[$];
  int          fd_cyc[$];
  int          cyc = 0;
  int          run = 0;
  int          max_run = 0;
  logic        exp_fd = 1'b0;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_d = '0;
  logic [1:0]  prev_fl = '0;

  logic [23:0] e1 [5] = '{24'h000001, 24'h000204, 24'h030507, 24'h060800, 24'h090000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lane k of beat t carries M[t-k][k]; padding outside the matrix is zero.
  function automatic void push_matrix();
    for (int t = 0; t < 5; t++) begin
      beat_t b;
      b.d = '0;
      for (int k = 0; k < 3; k++)
        if (t - k >= 0 && t - k < 3) b.d[k*8 +: 8] = rows[t-k][k*8 +: 8];
      b.f = (t == 0);
      b.l = (t == 4);
      exp_q.push_back(b);
    end
    rows.delete();
  endfunction

  always @(negedge clk) begin
    cyc++;
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
    if (prev_stall) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(prev_d));
      chk("stall_first_last", 32'({out_first, out_last}), 32'(prev_fl));
    end
    if (reset) begin
      exp_q.delete();
      rows.delete();
      exp_fd     = 1'b0;
      prev_stall = 1'b0;
      run        = 0;
    end else begin
      if (frame_done) fd_cyc.push_back(cyc);
      exp_fd = 1'b0;
      if (out_valid) begin
        run++;
        if (run > max_run) max_run = run;
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 32'(out_valid), 32'd0);
        end else begin
          chk("beat_data", 32'(out_data), 32'(exp_q[0].d));
          chk("beat_first", 32'(out_first), 32'(exp_q[0].f));
          chk("beat_last", 32'(out_last), 32'(exp_q[0].l));
          if (out_ready) begin
            got.push_back(out_data);
            exp_fd = exp_q[0].l;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        run = 0;
      end
      if (in_valid && in_ready) begin
        rows.push_back(in_data[23:0]);
        if (rows.size() == 3) push_matrix();
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_fl    = {out_first, out_last};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input logic [31:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("write_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int c;
    c = 0;
    while (got.size() < n && c < 200) begin
      tick();
      c++;
    end
    chk("beats_seen", 32'(got.size() >= n), 32'd1);
  endtask

  task automatic check_e1(input int base, input string name);
    for (int i = 0; i < 5; i++)
      if (got.size() > base + i) chk(name, 32'(got[base+i]), 32'(e1[i]));
  endtask

  task automatic write_e1();
    write_row(32'h00030201);
    write_row(32'h00060504);
    write_row(32'h00090807);
  endtask

  task automatic check_latency();
    @(negedge clk); chk("lat_c1_valid", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_c2_valid", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_c3_valid", 32'(out_valid), 32'd1);
    chk("lat_first_data", 32'(out_data), 32'h000001);
    chk("lat_first_flag", 32'(out_first), 32'd1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    int   c;
    logic r7;

    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_first_last", 32'({out_first, out_last}), 32'd0);
    chk("rst_bank_full", 32'(bank_full), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Single matrix
    out_ready = 1'b1;
    fd_cyc.delete();
    base = got.size();
    write_e1();
    check_latency();
    wait_got(base + 5);
    repeat (3) tick();
    check_e1(base, "single_beat");
    chk("single_fd_count", 32'(fd_cyc.size()), 32'd1);
    chk("single_bank_full", 32'(bank_full), 32'd0);

    // Back-to-back, top byte set to garbage on A
    fd_cyc.delete();
    max_run = 0;
    base = got.size();
    write_row(32'hAA0C0B0A);
    write_row(32'hAA0F0E0D);
    write_row(32'hAA121110);
    write_row(32'h00151413);
    write_row(32'h00181716);
    write_row(32'h001B1A19);
    wait_got(base + 10);
    repeat (3) tick();
    chk("b2b_run", 32'(max_run), 32'd10);
    chk("b2b_fd_count", 32'(fd_cyc.size()), 32'd2);
    if (fd_cyc.size() == 2) chk("b2b_fd_gap", 32'(fd_cyc[1] - fd_cyc[0]), 32'd5);
    if (got.size() >= base + 10) begin
      chk("b2b_a_beat2", 32'(got[base+2]), 32'h0C0E10);
      chk("b2b_b_beat0", 32'(got[base+5]), 32'h000013);
      chk("b2b_b_beat4", 32'(got[base+9]), 32'h1B0000);
    end

    // Backpressure at beat 2
    base = got.size();
    write_e1();
    c = 0;
    while (got.size() < base + 2 && c < 50) begin tick(); c++; end
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", 32'(out_data), 32'h030507);
    end
    tick();
    out_ready = 1'b1;
    wait_got(base + 5);
    repeat (3) tick();
    chk("bp_count", 32'(got.size() - base), 32'd5);
    check_e1(base, "bp_beat");

    // Both banks full, 7th row held
    out_ready = 1'b0;
    base = got.size();
    write_row(32'h00232221);
    write_row(32'h00262524);
    write_row(32'h00292827);
    write_row(32'h002C2B2A);
    write_row(32'h002F2E2D);
    write_row(32'h00323130);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_bank_full", 32'(bank_full), 32'd3);
    r7 = 1'b0;
    fork
      begin
        write_row(32'h00353433);
        r7 = 1'b1;
      end
    join_none
    repeat (5) tick();
    chk("full_held_ready", 32'(in_ready), 32'd0);
    chk("full_held_r7", 32'(r7), 32'd0);
    chk("full_held_beat", 32'(out_data), 32'h000021);
    out_ready = 1'b1;
    c = 0;
    while (!r7 && c < 100) begin tick(); c++; end
    chk("full_r7_accepted", 32'(r7), 32'd1);
    chk("full_a_drained", 32'(got.size() - base >= 5), 32'd1);
    write_row(32'h00383736);
    write_row(32'h003B3A39);
    wait_got(base + 15);
    repeat (3) tick();
    if (got.size() >= base + 15) begin
      chk("full_c_beat0", 32'(got[base+10]), 32'h000033);
      chk("full_c_beat4", 32'(got[base+14]), 32'h3B0000);
    end

    // Reset mid-stream at beat 2
    base = got.size();
    write_row(32'h00424140);
    write_row(32'h00454443);
    write_row(32'h00484746);
    c = 0;
    while (got.size() < base + 2 && c < 50) begin tick(); c++; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_bank_full", 32'(bank_full), 32'd0);
    chk("mid_rst_fd", 32'(frame_done), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (5) tick();
    base = got.size();
    write_e1();
    check_latency();
    wait_got(base + 5);
    repeat (3) tick();
    check_e1(base, "post_rst_beat");

    // Partial load then completion
    base = got.size();
    write_row(32'h00030201);
    write_row(32'h00060504);
    repeat (20) begin
      @(negedge clk);
      chk("partial_idle", 32'(out_valid), 32'd0);
    end
    tick();
    write_row(32'h00090807);
    check_latency();
    wait_got(base + 5);
    repeat (5) tick();
    check_e1(base, "partial_beat");

    chk("model_drained", 32'(exp_q.size()), 32'd0);
    chk("final_bank_full", 32'(bank_full), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sa_input_skewer.md
Name: sa_input_skewer

Overview:
- Upstream feeder for the 3x3 weight-stationary systolic array.
- Accepts activation matrices as 32-bit row words and double-buffers them in two banks.
- Emits each matrix as a diagonally skewed 24-bit stream: lane k is delayed k cycles, with zero padding, ready to drive the array's 24-bit input bus.
- Ping-pong banks let the next matrix load while the current one streams.

Parameters:
- N, 3, array dimension (rows/cols of matrix, number of output lanes)
- DW, 8, element width in bits (signed int8, passed through untouched)
- STEPS, 2*N-1 (5), derived localparam: stream beats per matrix

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_data  in  32  row word: bits[7:0]=col0, [15:8]=col1, [23:16]=col2, [31:24] ignored
- in_valid  in  1  in_data valid
- in_ready  out  1  skewer can accept a row word (combinational from bank state)
- out_data  out  24  skewed lanes: bits[8k+:8] = lane k
- out_valid  out  1  out_data holds a valid beat
- out_ready  in  1  consumer accepts beat (array enable)
- out_first  out  1  beat 0 of a matrix
- out_last  out  1  beat STEPS-1 of a matrix
- frame_done  out  1  one-cycle pulse after the last beat of a matrix is accepted
- bank_full  out  2  per-bank full flags (status)

Behaviour:
- Reset (synchronous, active-high): both banks empty, wr_bank=0, rd_bank=0, row counter=0, step counter=0. Outputs out_data=0, out_valid=0, out_first=0, out_last=0, frame_done=0, bank_full=2'b00. Asserting reset mid-stream or mid-load discards all partial data; no frame_done is issued.
- Write side:
  - in_ready = !bank_full[wr_bank].
  - A write occurs on in_valid && in_ready. It stores in_data[23:0] as row r (r = row counter) of bank wr_bank, then increments r.
  - On the N-th row (r==N-1): bank_full[wr_bank] is set next cycle, r returns to 0, and wr_bank toggles.
- Read FSM states:
  - IDLE: if bank_full[rd_bank], go to STREAM next cycle with step=0. The first beat is registered and visible (out_valid=1) one cycle after entering STREAM. Minimum latency from the accepted third row word to out_valid=1 is 2 cycles.
  - STREAM: out_data lane k = M[t-k][k] when 0 <= t-k < N, otherwise 0, where t is the current step and M[row][col] is the bank contents. out_first = (t==0); out_last = (t==STEPS-1).
  - Advance: on out_valid && out_ready, t increments and the next beat is registered.
  - Stall: on out_valid && !out_ready, out_data, out_first and out_last hold stable.
  - End of matrix: on acceptance of the beat with t==STEPS-1, clear bank_full[rd_bank], toggle rd_bank, pulse frame_done next cycle, then:
    - if the other bank is already full, continue STREAM with t=0 back-to-back, with no bubble (out_valid stays 1);
    - otherwise go to IDLE with out_valid=0.
- Skew for N=3:
  - t0 = {0,0,M00}
  - t1 = {0,M01,M10}
  - t2 = {M02,M11,M20}
  - t3 = {M12,M21,0}
  - t4 = {M22,0,0}
  - Listed {lane2,lane1,lane0}. Lane k carries column k; row index advances each beat.
- Simultaneous events:
  - A bank freeing and a write to the other bank in the same cycle are independent.
  - If wr_bank==rd_bank and the bank frees on the same edge a write would be refused, in_ready rises the following cycle. No combinational path from out_ready to in_ready.
- Both banks full: in_ready=0 until the streaming bank's last beat is accepted.
- Data is never modified. Zero padding uses literal 0.

Test Plan:
- Single matrix: write rows 0x00030201, 0x00060504, 0x00090807, out_ready=1 -> beats 0x000001, 0x000204, 0x030507, 0x060800, 0x090000. out_first on beat 0, out_last on beat 4, frame_done one cycle later, bank_full returns to 00.
- Back-to-back: write 6 rows (matrix A then B) with out_ready=1 -> 10 contiguous valid beats with no bubble between A and B. Two frame_done pulses, 5 cycles apart.
- Backpressure: drop out_ready for 3 cycles at beat 2 -> out_data holds 0x030507 for all stall cycles, and no beat is lost or duplicated.
- Full buffers: keep out_ready=0 and write 7 rows -> in_ready=0 after the 6th row is accepted and the 7th is held. Raising out_ready drains A, then in_ready returns and the 7th row lands in row 0 of bank 0.
- Reset mid-stream: assert reset at beat 2 of a matrix -> next cycle out_valid=0, bank_full=00, and no frame_done. A fresh matrix written afterward streams correctly from beat 0.
- Partial load: write 2 rows then idle 20 cycles -> out_valid stays 0. Writing the 3rd row starts the stream 2 cycles later.
